// File: rtl/zap_mem_pkg.sv
// Shared definitions for the ZAP memory responder: data FSM encoding,
// byte-lane geometry and the address limit compare used by the abort decode.
package zap_mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int LANE_W = 8;
    localparam int LANES  = 4;
    localparam int WORD_W = LANE_W * LANES;

    // True when a byte address is at or above a 33-bit limit (limit may be 2^32)
    function automatic logic addr_at_or_above(input logic [31:0] addr, input logic [32:0] limit);
        return ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/zap_mem_array.sv
// Backing store for the ZAP memory responder: four byte-lane RAMs with one
// lane-enabled write port and two asynchronous read ports (data, instruction).
module zap_mem_array
    import zap_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [LANES-1:0]  i_ben,
    input  logic [AW-1:0]     i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_draddr,
    output logic [WORD_W-1:0] o_drdata,
    input  logic [AW-1:0]     i_iraddr,
    output logic [WORD_W-1:0] o_irdata
);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W-1:0] lane_mem [DEPTH_WORDS];

        // Lane write: only enabled lanes of the addressed word change at the edge
        always_ff @(posedge i_clk) begin
            if (i_we && i_ben[g]) begin
                lane_mem[i_waddr] <= i_wdata[g*LANE_W +: LANE_W];
            end
        end

        // Reads are asynchronous, so a same-cycle fetch sees the pre-write word
        assign o_drdata[g*LANE_W +: LANE_W] = lane_mem[i_draddr];
        assign o_irdata[g*LANE_W +: LANE_W] = lane_mem[i_iraddr];
    end

endmodule

// File: rtl/zap_mem_responder.sv
// Target-side memory responder for the ZAP core: data port with programmable
// wait states, byte enables and range/user aborts; single-cycle fetch port.
module zap_mem_responder
    import zap_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RD_WAIT     = 2,
    parameter int          WR_WAIT     = 1,
    parameter logic [31:0] PROT_BASE   = 32'h0000_0200
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_daddress,
    input  logic        i_rd_en,
    input  logic        i_wr_en,
    input  logic [3:0]  i_ben,
    input  logic [31:0] i_ddata,
    input  logic        i_user,
    output logic [31:0] o_ddata,
    output logic        o_dstall,
    output logic        o_dabort,
    input  logic [31:0] i_iaddress,
    output logic [31:0] o_idata,
    output logic        o_ivalid,
    output logic        o_iabort
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] MEM_LIMIT  = 33'(DEPTH_WORDS) << 2;
    localparam logic [32:0] PROT_LIMIT = {1'b0, PROT_BASE};
    localparam logic [3:0]  RD_N       = 4'(RD_WAIT);
    localparam logic [3:0]  WR_N       = 4'(WR_WAIT);

    logic [1:0]        state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              ivalid_q, ivalid_d;

    logic              req_s, load_s, store_s, bad_s;
    logic [3:0]        wait_n_s;
    logic              complete_s, stall_s, abort_s, we_s, iabort_s;
    logic [WORD_W-1:0] drdata_s, irdata_s;

    assign req_s    = i_rd_en | i_wr_en;
    assign load_s   = i_rd_en & ~i_wr_en;
    assign store_s  = i_wr_en & ~i_rd_en;
    // Both enables together is a malformed request and aborts like a range error
    assign bad_s    = (i_rd_en & i_wr_en)
                    | addr_at_or_above(i_daddress, MEM_LIMIT)
                    | (i_user & addr_at_or_above(i_daddress, PROT_LIMIT));
    assign wait_n_s = i_wr_en ? WR_N : RD_N;

    // Data FSM next state, wait counter and combinational handshake outputs
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ivalid_d   = ~i_reset;
        complete_s = 1'b0;
        stall_s    = 1'b0;
        abort_s    = 1'b0;
        if (i_reset) begin
            // Reset kills any in-flight access, including a store about to commit
            state_d    = ST_IDLE;
            wait_cnt_d = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!req_s) begin
                        state_d = ST_IDLE;
                    end else if (bad_s) begin
                        abort_s = 1'b1;
                    end else if (wait_n_s == 4'd0) begin
                        complete_s = 1'b1;
                    end else begin
                        // This IDLE cycle is the first of N stall cycles
                        stall_s    = 1'b1;
                        wait_cnt_d = wait_n_s - 4'd1;
                        state_d    = (wait_n_s == 4'd1) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!req_s) begin
                        state_d    = ST_IDLE;
                        wait_cnt_d = 4'd0;
                    end else begin
                        stall_s    = 1'b1;
                        wait_cnt_d = wait_cnt_q - 4'd1;
                        state_d    = (wait_cnt_q <= 4'd1) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_DONE: begin
                    // A dropped request simply returns to IDLE without completing
                    state_d    = ST_IDLE;
                    wait_cnt_d = 4'd0;
                    complete_s = req_s;
                end
                default: begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // State, wait counter and fetch-valid registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            ivalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ivalid_q   <= ivalid_d;
        end
    end

    assign we_s     = complete_s & store_s;
    assign o_dstall = stall_s;
    assign o_dabort = abort_s;
    assign o_ddata  = (complete_s & load_s) ? drdata_s : 32'h0000_0000;

    assign iabort_s = ivalid_q & addr_at_or_above(i_iaddress, MEM_LIMIT);
    assign o_iabort = iabort_s;
    assign o_ivalid = ivalid_q;
    assign o_idata  = iabort_s ? 32'h0000_0000 : irdata_s;

    zap_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .i_clk    (i_clk),
        .i_we     (we_s),
        .i_ben    (i_ben),
        .i_waddr  (i_daddress[AW+1:2]),
        .i_wdata  (i_ddata),
        .i_draddr (i_daddress[AW+1:2]),
        .o_drdata (drdata_s),
        .i_iraddr (i_iaddress[AW+1:2]),
        .o_irdata (irdata_s)
    );

endmodule
